// File: rtl/adc_stream_merger_pkg.sv
// Shared types for the ADC stream merger: FSM state encoding and counter width.
package adc_stream_merger_pkg;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping modulo N.
module rr_arbiter
  import adc_stream_merger_pkg::*;
#(
  parameter  int N  = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  int j;
  logic [PW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        idx     = jj;
        gnt[jj] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_stream_merger.sv
// Merges NUM_STREAMS ADC AXIS inputs into fixed-length packets on one AXIS master,
// round-robin between valid streams, one word per cycle when the sink keeps up.
module adc_stream_merger
  import adc_stream_merger_pkg::*;
#(
  parameter int AXIS_BYTES  = 4,
  parameter int NUM_STREAMS = 8,
  parameter int TDEST_WIDTH = 8
) (
  input  logic                                 CLK100MHz,
  input  logic                                 ARESETN,
  input  logic                                 enable,
  input  logic [31:0]                          words_to_send,
  input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]  s_axis_tdata,
  input  logic [NUM_STREAMS*TDEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [NUM_STREAMS-1:0]               s_axis_tvalid,
  output logic [NUM_STREAMS-1:0]               s_axis_tready,
  output logic [AXIS_BYTES*8-1:0]              m_axis_tdata,
  output logic [TDEST_WIDTH-1:0]               m_axis_tdest,
  output logic [AXIS_BYTES-1:0]                m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic                                 busy,
  output logic [31:0]                          packets_done
);
  localparam int DW = AXIS_BYTES * 8;
  localparam int PW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  logic [NUM_STREAMS-1:0][DW-1:0]          lane_data;
  logic [NUM_STREAMS-1:0][TDEST_WIDTH-1:0] lane_dest;
  assign lane_data = s_axis_tdata;
  assign lane_dest = s_axis_tdest;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [CNT_W-1:0] len, cnt;

  logic [NUM_STREAMS-1:0] gnt;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_any;

  rr_arbiter #(.N(NUM_STREAMS)) u_arb (
    .req (s_axis_tvalid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  logic can_load, accept, last_word;
  assign can_load      = !m_axis_tvalid || m_axis_tready;
  assign accept        = (state == ST_RUN) && can_load && gnt_any;
  assign last_word     = (cnt == len - 1'b1);
  assign s_axis_tready = accept ? gnt : '0;
  assign m_axis_tkeep  = '1;
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      len           <= '0;
      cnt           <= '0;
      packets_done  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && words_to_send != '0) begin
            len   <= words_to_send;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            m_axis_tdata  <= lane_data[gnt_idx];
            m_axis_tdest  <= lane_dest[gnt_idx];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_word;
            cnt           <= cnt + 1'b1;
            ptr           <= (gnt_idx == PW'(NUM_STREAMS - 1)) ? '0 : gnt_idx + 1'b1;
            if (last_word) state <= ST_FLUSH;
          end else if (m_axis_tready) begin
            // previous word drained and nothing valid to replace it
            m_axis_tvalid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            packets_done  <= packets_done + 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_stream_merger.sv
// Bench for adc_stream_merger: directed packet table, hand corner cases, random run vs model.
module tb_adc_stream_merger;
  localparam int N = 8, B = 4, DW = 32, TW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, enable, m_tready;
  logic [31:0]     wts;
  logic [N*DW-1:0] s_tdata;
  logic [N*TW-1:0] s_tdest;
  logic [N-1:0]    s_tvalid, s_tready;
  logic [DW-1:0]   m_tdata;
  logic [TW-1:0]   m_tdest;
  logic [B-1:0]    m_tkeep;
  logic            m_tvalid, m_tlast, busy;
  logic [31:0]     pdone;

  adc_stream_merger dut (
    .CLK100MHz(clk), .ARESETN(rst_n), .enable(enable), .words_to_send(wts),
    .s_axis_tdata(s_tdata), .s_axis_tdest(s_tdest), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tdest(m_tdest),
    .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .busy(busy), .packets_done(pdone)
  );

  int n_tests = 0, n_fail = 0;
  int got[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_streams(input logic [7:0] mask);
    for (int k = 0; k < N; k++) begin
      s_tvalid[k]          = mask[k];
      s_tdest[k*TW +: TW]  = TW'(k + 1);
      s_tdata[k*DW +: DW]  = 32'hA500_0000 | k;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; wts = '0; m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tdest = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tlast"},  m_tlast, 0);
    chk({tag, "_tdata"},  m_tdata, 0);
    chk({tag, "_tdest"},  m_tdest, 0);
    chk({tag, "_sready"}, s_tready, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_pdone"},  pdone, 0);
  endtask

  // Gathers output tdest values until tlast or max_words; optional 3-cycle stall / enable drop.
  task automatic collect(input int max_cyc, input int max_words, input int stall_at,
                         input int drop_at, output int cnt, output int last_at);
    logic [TW-1:0] hold;
    bit stalled;
    stalled = 0; cnt = 0; last_at = -1;
    for (int c = 0; c < max_cyc && last_at < 0 && cnt < max_words; c++) begin
      @(negedge clk);
      if (cnt == drop_at) enable = 1'b0;
      if (cnt == stall_at && !stalled && m_tvalid) begin
        stalled = 1; m_tready = 1'b0; hold = m_tdest;
        repeat (3) begin
          #1;
          chk("stall_sready", s_tready, 0);
          chk("stall_hold",   m_tdest, hold);
          chk("stall_valid",  m_tvalid, 1);
          @(negedge clk);
        end
        m_tready = 1'b1;
      end
      if (m_tvalid && m_tready) begin
        got[cnt] = m_tdest;
        if (m_tlast) last_at = cnt;
        cnt++;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  vmask;
    int          len;
    logic [63:0] seq;   // expected stream index per word, one nibble each
    int          stall_at;
    int          drop_at;
  } vec_t;
  vec_t vt[7];

  typedef struct packed { logic [31:0] d; logic [7:0] t; logic l; } word_t;
  word_t q[$];

  initial begin
    int cnt, last_at, phase, nphase, rptr, rem, g, k;
    logic [31:0] mdone;
    logic [N-1:0] exp_rdy;
    logic [3:0] nib;
    bit loadable, found;
    word_t w;

    vt[0] = '{8'hff, 8, 64'h76543210, -1, -1};
    vt[1] = '{8'h24, 4, 64'h5252,     -1, -1};
    vt[2] = '{8'h81, 5, 64'h07070,    -1, -1};
    vt[3] = '{8'h80, 2, 64'h77,       -1, -1};
    vt[4] = '{8'hff, 8, 64'h76543210,  3, -1};
    vt[5] = '{8'hff, 6, 64'h543210,   -1,  2};
    vt[6] = '{8'h01, 3, 64'h000,       1, -1};

    do_reset();
    #1 chk_reset_outputs("rst");

    foreach (vt[v]) begin
      do_reset();
      set_streams(vt[v].vmask);
      wts = vt[v].len; m_tready = 1'b1; enable = 1'b1;
      collect(200, 64, vt[v].stall_at, vt[v].drop_at, cnt, last_at);
      enable = 1'b0;
      chk($sformatf("v%0d_count", v), cnt, vt[v].len);
      chk($sformatf("v%0d_last_pos", v), last_at, vt[v].len - 1);
      for (int i = 0; i < cnt && i < vt[v].len; i++) begin
        nib = vt[v].seq[i*4 +: 4];
        chk($sformatf("v%0d_w%0d_tdest", v, i), got[i], nib + 1);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_pdone", v), pdone, 1);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_tkeep", v), m_tkeep, 4'hf);
    end

    // zero-length request never starts a packet
    do_reset();
    set_streams(8'hff);
    wts = 0; enable = 1'b1; m_tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("zero_len_busy", busy, 0);
      chk("zero_len_tvalid", m_tvalid, 0);
    end

    // reset mid-packet, then restart from stream 0
    do_reset();
    set_streams(8'hff);
    wts = 8; enable = 1'b1; m_tready = 1'b1;
    collect(100, 3, -1, -1, cnt, last_at);
    chk("midrst_words_before", cnt, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    collect(200, 64, -1, -1, cnt, last_at);
    enable = 1'b0;
    chk("midrst_restart_count", cnt, 8);
    chk("midrst_restart_first", got[0], 1);
    chk("midrst_restart_last", last_at, 7);

    // randomized run against a transaction-level model
    do_reset();
    phase = 0; rptr = 0; rem = 0; mdone = '0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_tvalid = ($urandom % 3 == 0) ? N'($urandom) : N'($urandom) & N'($urandom);
      for (int s = 0; s < N; s++) begin
        s_tdata[s*DW +: DW] = $urandom;
        s_tdest[s*TW +: TW] = TW'($urandom);
      end
      m_tready = ($urandom % 4) != 0;
      enable   = ($urandom % 8) != 0;
      wts      = $urandom % 6;
      #1;
      chk("r_tvalid", m_tvalid, q.size() != 0);
      chk("r_busy", busy, phase != 0);
      chk("r_pdone", pdone, mdone);
      nphase   = phase;
      loadable = (q.size() == 0) || m_tready;
      if (m_tvalid && m_tready) begin
        chk("r_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          w = q.pop_front();
          chk("r_tdata", m_tdata, w.d);
          chk("r_tdest", m_tdest, w.t);
          chk("r_tlast", m_tlast, w.l);
          if (w.l) begin mdone++; nphase = 0; end
        end
      end
      exp_rdy = '0; found = 0; g = 0;
      if (phase == 1 && loadable) begin
        for (int i = 0; i < N && !found; i++) begin
          k = (rptr + i) % N;
          if (s_tvalid[k]) begin found = 1; g = k; end
        end
        if (found) begin
          exp_rdy[g] = 1'b1;
          q.push_back('{s_tdata[g*DW +: DW], s_tdest[g*TW +: TW], rem == 1});
          rptr = (g + 1) % N;
          rem--;
          if (rem == 0) nphase = 2;
        end
      end
      chk("r_sready", s_tready, exp_rdy);
      if (phase == 0 && enable && wts != 0) begin
        rem = wts; nphase = 1;
      end
      phase = nphase;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_stream_merger.md
ADC_STREAM_MERGER -- requirements
Module: adc_stream_merger

Interface
REQ-001 Parameter AXIS_BYTES, default 4: bytes per AXIS word on every input and on the output.
REQ-002 Parameter NUM_STREAMS, default 8: number of slave AXIS inputs (one per ADC pair, range 2..16).
REQ-003 Parameter TDEST_WIDTH, default 8: tdest width on inputs and output.
REQ-004 Port CLK100MHz, input, 1: sole clock; all logic is rising-edge.
REQ-005 Port ARESETN, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port enable, input, 1: arms packet generation (EnableSampleGeneration register).
REQ-007 Port words_to_send, input, 32: packet length in words (PacketSize register), sampled at packet start.
REQ-008 Port s_axis_tdata, input, NUM_STREAMS*AXIS_BYTES*8: packed input data; stream k occupies slice k.
REQ-009 Port s_axis_tdest, input, NUM_STREAMS*TDEST_WIDTH: packed input tdest.
REQ-010 Port s_axis_tvalid, input, NUM_STREAMS: per-stream valid.
REQ-011 Port s_axis_tready, output, NUM_STREAMS: per-stream ready.
REQ-012 Ports m_axis_tdata (AXIS_BYTES*8), m_axis_tdest (TDEST_WIDTH), m_axis_tkeep (AXIS_BYTES), m_axis_tvalid (1), m_axis_tlast (1), outputs; m_axis_tready, input, 1: merged AXIS master.
REQ-013 Port busy, output, 1: high in RUN or FLUSH.
REQ-014 Port packets_done, output, 32: count of completed packets.

Function
REQ-015 States: IDLE, RUN, FLUSH.
REQ-016 IDLE: all s_axis_tready low; on enable=1 and words_to_send!=0, latch words_to_send into len register, clear word counter, enter RUN next cycle.
REQ-017 IDLE with words_to_send=0: stay in IDLE, no transfer.
REQ-018 RUN: output register "can load" when m_axis_tvalid=0 or m_axis_tready=1.
REQ-019 RUN grant: first stream with tvalid=1 searching from round-robin pointer ptr upward, wrapping modulo NUM_STREAMS.
REQ-020 When can load and a grant exists, s_axis_tready is high only for the granted stream that cycle; all others low.
REQ-021 On accepted input, the output register loads tdata/tdest of the granted stream next cycle; m_axis_tkeep all ones; latency input handshake -> m_axis_tvalid = 1 cycle.
REQ-022 After each accept, ptr = grant+1 (wrapping NUM_STREAMS-1 -> 0).
REQ-023 Word counter increments per accept; accept with counter = len-1 sets m_axis_tlast on that word and enters FLUSH.
REQ-024 Sustained throughput: one word per cycle with m_axis_tready=1 and any input valid.
REQ-025 While m_axis_tvalid=1 and m_axis_tready=0, tdata/tdest/tlast held stable and no input accepted.
REQ-026 enable deasserted mid-packet: packet completes to len words; enable only sampled in IDLE.
REQ-027 FLUSH: no inputs accepted; when last word handshakes, packets_done increments (wraps 2^32-1 -> 0), return to IDLE.
REQ-028 Back-to-back packets: with enable held high, new packet starts one cycle after return to IDLE (one-cycle gap).
REQ-029 words_to_send changes during RUN are ignored.

Reset
REQ-030 ARESETN low asynchronously forces: state IDLE, ptr 0, counters 0, packets_done 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tdest 0, s_axis_tready 0.
REQ-031 Reset mid-packet discards the partial packet; no tlast emitted.

Structure
REQ-032 Shared package holds the state enum and a localparam for counter width (32).
REQ-033 One sub-module, rr_arbiter (NUM_STREAMS requests, pointer in, one-hot grant + index out, combinational).

Verification
REQ-034 N=8, len=8, all valid, tready=1 -> 8 consecutive words, tdest 1..8 in order, tlast on 8th, packets_done=1.
REQ-035 Only streams 2 and 5 valid, len=4 -> order 2,5,2,5; tlast on 4th.
REQ-036 tready low for 3 cycles mid-packet -> output word held stable, no s_axis_tready pulses, no word lost or duplicated.
REQ-037 enable drops after word 2 of len=6 -> all 6 words emitted, tlast on 6th, then busy low.
REQ-038 words_to_send=0 with enable=1 -> busy stays 0, no tvalid for 20 cycles.
REQ-039 ARESETN asserted after word 3 of len=8 -> all outputs reset immediately; after release, new packet starts at stream 0.
